// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared opcodes, FSM states and instruction field slices
// for the multi-cycle core (optional counters: MC_CPU_PERF_EN).
package mc_cpu_pkg;

    localparam int IW  = 16;
    localparam int RIW = 4;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 8;
    localparam int RA_HI   = 7;
    localparam int RA_LO   = 4;
    localparam int RB_HI   = 3;
    localparam int RB_LO   = 0;
    localparam int TGT_HI  = 11;
    localparam int TGT_LO  = 4;
    localparam int IMM8_HI = 7;
    localparam int IMM8_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LI   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_ADDI = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_JAL  = 4'hA,
        OP_JR   = 4'hB,
        OP_BEZ  = 4'hC,
        OP_BNZ  = 4'hD,
        OP_SHR  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    function automatic logic op_writes(input opcode_e op);
        case (op)
            OP_LI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_LD, OP_JAL, OP_SHR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_cpu_regfile.sv
// mc_cpu_regfile: NREG x DW registers, two operand reads, one debug read.
// Indices at or above NREG read as zero and drop writes.
module mc_cpu_regfile
    import mc_cpu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RIW-1:0] ra_idx,
    output logic [DW-1:0]  ra_data,
    input  logic [RIW-1:0] rb_idx,
    output logic [DW-1:0]  rb_data,
    input  logic [RIW-1:0] dbg_idx,
    output logic [DW-1:0]  dbg_data,
    input  logic           we,
    input  logic [RIW-1:0] waddr,
    input  logic [DW-1:0]  wdata
);

    logic [DW-1:0] regs [NREG];

    function automatic logic [DW-1:0] rd_reg(input logic [RIW-1:0] idx);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == RIW'(i)) v = regs[i];
        end
        return v;
    endfunction

    always_comb begin
        ra_data  = rd_reg(ra_idx);
        rb_data  = rd_reg(rb_idx);
        dbg_data = rd_reg(dbg_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we && waddr == RIW'(i)) regs[i] <= wdata;
            end
        end
    end

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with
// req/ack memory ports. MC_CPU_PERF_EN adds cycle/instret counters.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int          DW       = 8,
    parameter int          AW       = 8,
    parameter int          NREG     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           CLK,
    input  logic           RST_N,
    output logic           imem_req,
    output logic [AW-1:0]  imem_addr,
    input  logic [IW-1:0]  imem_rdata,
    input  logic           imem_ack,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [AW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic [DW-1:0]  dmem_rdata,
    input  logic           dmem_ack,
    output logic [AW-1:0]  pc,
    output logic           halted,
    input  logic [RIW-1:0] dbg_raddr,
    output logic [DW-1:0]  dbg_rdata
`ifdef MC_CPU_PERF_EN
    ,
    output logic [31:0]    cycle_cnt,
    output logic [31:0]    instret_cnt
`endif
);

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic [DW-1:0] opa_q, opb_q, res_q;
    logic [AW-1:0] pc_q, npc_q;

    opcode_e       op;
    logic          is_mem, is_halt;
    logic [DW-1:0] ra_data, rb_data;
    logic [DW-1:0] exe_res, imm4_sx;
    logic [AW-1:0] exe_npc, pc_inc;
    logic          rf_we;

    assign op      = opcode_e'(ir_q[OPC_HI:OPC_LO]);
    assign is_mem  = (op == OP_LD) || (op == OP_ST);
    assign is_halt = (op == OP_HALT);

    mc_cpu_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk      (CLK),
        .rst_n    (RST_N),
        .ra_idx   (ir_q[RA_HI:RA_LO]),
        .ra_data  (ra_data),
        .rb_idx   (ir_q[RB_HI:RB_LO]),
        .rb_data  (rb_data),
        .dbg_idx  (dbg_raddr),
        .dbg_data (dbg_rdata),
        .we       (rf_we),
        .waddr    (ir_q[RD_HI:RD_LO]),
        .wdata    (res_q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                unique case (1'b1)
                    is_mem:  state_d = ST_MEM;
                    is_halt: state_d = ST_HALT;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM:    if (dmem_ack) state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Operands come from the DECODE latches, so rd==ra/rb is harmless.
    always_comb begin
        pc_inc  = pc_q + AW'(1);
        imm4_sx = DW'($signed(ir_q[RA_HI:RA_LO]));
        exe_res = '0;
        exe_npc = pc_inc;
        unique case (op)
            OP_LI:   exe_res = DW'(ir_q[IMM8_HI:IMM8_LO]);
            OP_ADD:  exe_res = opa_q + opb_q;
            OP_SUB:  exe_res = opa_q - opb_q;
            OP_AND:  exe_res = opa_q & opb_q;
            OP_OR:   exe_res = opa_q | opb_q;
            OP_XOR:  exe_res = opa_q ^ opb_q;
            OP_ADDI: exe_res = imm4_sx + opb_q;
            OP_SHR:  exe_res = opb_q >> 1;
            OP_JAL: begin
                exe_res = DW'(pc_inc);
                exe_npc = AW'(ir_q[IMM8_HI:IMM8_LO]);
            end
            OP_JR:   exe_npc = AW'(opb_q);
            OP_BEZ:  if (!opb_q[0]) exe_npc = AW'(ir_q[TGT_HI:TGT_LO]);
            OP_BNZ:  if (opb_q[0])  exe_npc = AW'(ir_q[TGT_HI:TGT_LO]);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= AW'(RESET_PC);
            ir_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            npc_q <= '0;
        end else begin
            unique case (state_q)
                ST_FETCH: if (imem_ack) ir_q <= imem_rdata;
                ST_DECODE: begin
                    opa_q <= ra_data;
                    opb_q <= rb_data;
                end
                ST_EXEC: begin
                    res_q <= exe_res;
                    npc_q <= exe_npc;
                end
                ST_MEM:  if (dmem_ack && op == OP_LD) res_q <= dmem_rdata;
                ST_WB:   pc_q <= npc_q;
                default: ;
            endcase
        end
    end

    assign rf_we = (state_q == ST_WB) && op_writes(op);

    // imem_req is gated by reset since the reset state itself is FETCH.
    assign imem_req   = RST_N && (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = (state_q == ST_MEM) && (op == OP_ST);
    assign dmem_addr  = AW'(opa_q);
    assign dmem_wdata = opb_q;
    assign pc         = pc_q;
    assign halted     = (state_q == ST_HALT);

`ifdef MC_CPU_PERF_EN
    // The cycle that enters HALT is still counted; freezing starts after it.
    logic frz_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frz_q       <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            frz_q <= (state_q == ST_HALT);
            if (!frz_q) cycle_cnt <= cycle_cnt + 32'd1;
            if (state_q == ST_WB || (state_q == ST_EXEC && is_halt))
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
